// File: rtl/sst_seq_engine_pkg.sv
// Shared types and constants for the save-state sequencing engine.
// Mapper register space and FSM state encoding.
package sst_seq_engine_pkg;

  localparam int SST_ADDR_W       = 8;
  localparam int SST_MAP_IDX_ADDR = 127;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK_A,
    S_CHK_B,
    S_SETL,
    S_CAP,
    S_RDB,
    S_WR,
    S_NEXT,
    S_DONE,
    S_ERR
  } sst_state_t;

endpackage

// File: rtl/sst_seq_engine.sv
// Save-state bus initiator: dumps mapper registers into a snapshot
// buffer, or restores them via M2-synchronised register writes.
module sst_seq_engine
  import sst_seq_engine_pkg::*;
#(
  parameter int LAST_ADDR  = SST_MAP_IDX_ADDR,
  parameter int SETTLE     = 2,
  parameter int WR_TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  m2_fall,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sst_act,
  output logic [SST_ADDR_W-1:0] sst_addr,
  output logic                  sst_we_reg,
  output logic [7:0]            sst_dato,
  input  logic [7:0]            sst_di,
  output logic [SST_ADDR_W-1:0] buf_addr,
  output logic                  buf_we,
  output logic [7:0]            buf_wdata,
  input  logic [7:0]            buf_rdata
);

  localparam int AW = SST_ADDR_W;
  localparam int CW = 8;
  localparam int TW = $clog2(WR_TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_A  = AW'(LAST_ADDR);
  localparam logic [AW-1:0] LAST_W  = AW'(LAST_ADDR - 1);
  localparam logic [CW-1:0] SET_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] RDB_END = CW'(1);
  localparam logic [TW-1:0] TMO_END = TW'(WR_TIMEOUT - 1);

  sst_state_t     r_state;
  logic [AW-1:0]  r_addr;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_tmo;
  logic           r_dir;
  logic           r_hold;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_we;
  logic [7:0]     r_dato;
  logic           r_buf_we;
  logic [7:0]     r_buf_wdata;
  logic [AW-1:0]  w_final;

  assign w_final = r_dir ? LAST_W : LAST_A;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_dir       <= 1'b0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_dato      <= '0;
      r_buf_we    <= 1'b0;
      r_buf_wdata <= '0;
    end else begin
      r_done   <= 1'b0;
      r_buf_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_dir  <= dir;
            r_cnt  <= '0;
            if (dir) begin
              r_addr  <= LAST_A;
              r_state <= S_CHK_A;
            end else begin
              r_addr  <= '0;
              r_state <= S_SETL;
            end
          end
        end
        S_CHK_A: begin
          r_cnt   <= '0;
          r_state <= S_CHK_B;
        end
        // Live map_idx must match the snapshot before any write happens.
        S_CHK_B: begin
          if (r_cnt == SET_END) begin
            r_cnt  <= '0;
            r_addr <= '0;
            if (sst_di == buf_rdata) begin
              r_state <= S_RDB;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERR;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SETL: begin
          if (r_cnt == SET_END) begin
            r_cnt   <= '0;
            r_state <= S_CAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CAP: begin
          r_buf_we    <= 1'b1;
          r_buf_wdata <= sst_di;
          r_state     <= S_NEXT;
        end
        // Second RDB cycle sees buffer data for the new address.
        S_RDB: begin
          if (r_cnt == RDB_END) begin
            r_cnt   <= '0;
            r_dato  <= buf_rdata;
            r_we    <= 1'b1;
            r_tmo   <= '0;
            r_hold  <= 1'b0;
            r_state <= S_WR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR: begin
          if (r_hold) begin
            r_we    <= 1'b0;
            r_hold  <= 1'b0;
            r_state <= S_NEXT;
          end else if (m2_fall) begin
            r_hold <= 1'b1;
          end else if (r_tmo == TMO_END) begin
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_state <= S_ERR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_NEXT: begin
          if (r_addr == w_final) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + AW'(1);
            r_cnt   <= '0;
            r_state <= r_dir ? S_RDB : S_SETL;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign sst_act    = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign sst_addr   = r_addr;
  assign buf_addr   = r_addr;
  assign sst_we_reg = r_we;
  assign sst_dato   = r_dato;
  assign buf_we     = r_buf_we;
  assign buf_wdata  = r_buf_wdata;

endmodule

// File: tb/tb_sst_seq_engine.sv
// Directed bench for sst_seq_engine with a mapper register model
// and a 1-cycle-latency snapshot buffer model.
module tb_sst_seq_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic       m2_fall;
  logic       busy;
  logic       done;
  logic       err;
  logic       sst_act;
  logic [7:0] sst_addr;
  logic       sst_we_reg;
  logic [7:0] sst_dato;
  logic [7:0] sst_di;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdata;
  logic [7:0] buf_rdata;

  logic [7:0] regs [128];
  logic [7:0] bmem [256];
  int reg_init = 0;
  int buf_init = 0;
  int m2_mode  = 0;
  int m2_cnt   = 0;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int we_cyc   = 0;
  int we_rise  = 0;
  int we127    = 0;
  logic we_prev = 1'b0;

  sst_seq_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .m2_fall    (m2_fall),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sst_act    (sst_act),
    .sst_addr   (sst_addr),
    .sst_we_reg (sst_we_reg),
    .sst_dato   (sst_dato),
    .sst_di     (sst_di),
    .buf_addr   (buf_addr),
    .buf_we     (buf_we),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bpat(input int sel, input int i);
    logic [7:0] v;
    v = 8'h00;
    if (i < 127) begin
      if (sel == 3) v = 8'(i * 3);
      else          v = ~8'(i);
    end else if (i == 127) begin
      v = (sel == 2) ? 8'd4 : 8'd69;
    end
    return v;
  endfunction

  // Mapper: combinational read, latch on m2_fall while write strobe high
  assign sst_di = regs[sst_addr[6:0]];

  always @(posedge clk) begin
    if (reg_init == 1) begin
      for (int i = 0; i < 128; i++)
        regs[i] <= (i == 127) ? 8'd69 : (8'(i) ^ 8'hA5);
    end else if (reg_init == 2) begin
      for (int i = 0; i < 127; i++) regs[i] <= 8'h00;
    end else if (m2_fall && sst_we_reg) begin
      regs[sst_addr[6:0]] <= sst_dato;
    end
  end

  always @(posedge clk) begin
    if (buf_init != 0) begin
      for (int i = 0; i < 256; i++) bmem[i] <= bpat(buf_init, i);
    end else if (buf_we) begin
      bmem[buf_addr] <= buf_wdata;
    end
    buf_rdata <= bmem[buf_addr];
  end

  initial begin
    m2_fall = 1'b0;
    forever begin
      @(negedge clk);
      m2_cnt++;
      case (m2_mode)
        1: m2_fall = (m2_cnt % 20 == 0);
        2: m2_fall = sst_we_reg ? (m2_cnt % 7 == 0) : busy;
        default: m2_fall = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sst_we_reg) begin
      we_cyc++;
      if (sst_addr == 8'd127) we127++;
    end
    if (sst_we_reg && !we_prev) we_rise++;
    we_prev = sst_we_reg;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic d);
    dir   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_for(input string tag, input bit idle,
                          input int budget, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < budget) begin
      @(negedge clk);
      cyc++;
      hit = idle ? ~busy : done;
    end
    check({tag, " reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic load(input int rsel, input int bsel);
    reg_init = rsel;
    buf_init = bsel;
    @(negedge clk);
    reg_init = 0;
    buf_init = 0;
  endtask

  function automatic int reg_mis(input int sel);
    int n;
    n = 0;
    for (int i = 0; i < 127; i++)
      if (regs[i] !== bpat(sel, i)) n++;
    return n;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " flags"},
          {26'd0, busy, done, err, sst_act, sst_we_reg, buf_we}, 32'd0);
    check({tag, " addr"}, {16'd0, sst_addr, buf_addr}, 32'd0);
    check({tag, " data"}, {16'd0, sst_dato, buf_wdata}, 32'd0);
  endtask

  int cyc;
  int d0;
  int w0;
  int r0;
  int c0;
  int nmis;
  bit found;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    dir   = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    load(1, 0);

    // DUMP
    d0 = done_cnt;
    r0 = we_rise;
    pulse_start(1'b0);
    check("dump busy", {30'd0, busy, sst_act}, 32'd3);
    wait_for("dump done", 1'b0, 1000, cyc);
    check("dump cycles", 32'(cyc + 1), 32'd513);
    check("dump end flags", {29'd0, busy, sst_act, err}, 32'd0);
    repeat (20) @(negedge clk);
    nmis = 0;
    for (int i = 0; i < 127; i++)
      if (bmem[i] !== (8'(i) ^ 8'hA5)) nmis++;
    check("dump buf mismatches", 32'(nmis), 32'd0);
    check("dump buf0", {24'd0, bmem[0]}, 32'hA5);
    check("dump buf126", {24'd0, bmem[126]}, 32'hDB);
    check("dump buf127", {24'd0, bmem[127]}, 32'd69);
    check("dump done count", 32'(done_cnt - d0), 32'd1);
    check("dump no writes", 32'(we_rise - r0), 32'd0);

    // RESTORE, M2 every 20 clocks
    load(0, 1);
    m2_mode = 1;
    d0 = done_cnt;
    r0 = we_rise;
    w0 = we127;
    pulse_start(1'b1);
    wait_for("rest done", 1'b0, 8000, cyc);
    check("rest err", {31'd0, err}, 32'd0);
    repeat (20) @(negedge clk);
    check("rest reg mismatches", 32'(reg_mis(1)), 32'd0);
    check("rest reg0", {24'd0, regs[0]}, 32'hFF);
    check("rest reg127", {24'd0, regs[127]}, 32'd69);
    check("rest write count", 32'(we_rise - r0), 32'd127);
    check("rest no write 127", 32'(we127 - w0), 32'd0);
    check("rest done count", 32'(done_cnt - d0), 32'd1);

    // RESTORE with wrong map_idx
    load(0, 2);
    d0 = done_cnt;
    r0 = we_rise;
    pulse_start(1'b1);
    wait_for("idx busy fall", 1'b1, 50, cyc);
    check("idx err", {31'd0, err}, 32'd1);
    repeat (5) @(negedge clk);
    check("idx err sticky", {29'd0, err, busy, sst_act}, 32'd4);
    check("idx no writes", 32'(we_rise - r0), 32'd0);
    check("idx no done", 32'(done_cnt - d0), 32'd0);

    // RESTORE with no M2 edges: write times out
    m2_mode = 0;
    load(2, 1);
    c0 = we_cyc;
    pulse_start(1'b1);
    check("tmo err cleared", {30'd0, err, busy}, 32'd1);
    wait_for("tmo busy fall", 1'b1, 6000, cyc);
    repeat (2) @(negedge clk);
    check("tmo flags", {29'd0, err, sst_we_reg, sst_act}, 32'd4);
    check("tmo we cycles", 32'(we_cyc - c0), 32'd4095);
    check("tmo reg0 untouched", {24'd0, regs[0]}, 32'd0);

    // Reset mid-RESTORE at address 40
    m2_mode = 1;
    load(2, 1);
    pulse_start(1'b1);
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (sst_addr == 8'd40 && sst_we_reg) found = 1'b1;
    end
    check("rst reach addr40", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst mid");
    rst = 1'b0;
    check("rst reg39 written", {24'd0, regs[39]}, 32'hD8);
    check("rst reg41 untouched", {24'd0, regs[41]}, 32'd0);
    @(negedge clk);
    pulse_start(1'b1);
    wait_for("rerun done", 1'b0, 8000, cyc);
    check("rerun err", {31'd0, err}, 32'd0);
    repeat (5) @(negedge clk);
    check("rerun reg mismatches", 32'(reg_mis(1)), 32'd0);

    // Restart attempts while busy; M2 also pulses outside WR
    m2_mode = 2;
    load(2, 3);
    d0 = done_cnt;
    w0 = we127;
    pulse_start(1'b1);
    repeat (50) @(negedge clk);
    pulse_start(1'b0);
    repeat (250) @(negedge clk);
    pulse_start(1'b1);
    wait_for("busy-start done", 1'b0, 5000, cyc);
    repeat (30) @(negedge clk);
    check("busy-start done count", 32'(done_cnt - d0), 32'd1);
    check("busy-start reg mismatches", 32'(reg_mis(3)), 32'd0);
    check("busy-start reg126", {24'd0, regs[126]}, 32'h7A);
    check("busy-start reg127", {24'd0, regs[127]}, 32'd69);
    check("busy-start no write 127", 32'(we127 - w0), 32'd0);
    check("busy-start idle", {30'd0, busy, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
